kw_arb_client: RTL
==================

Name: KW_arb_client

Overview:
- Client-side requester for the static-priority lock arbiter; one instance per arbiter slot.
- Buffers an upstream valid/ready packet stream and drives that slot's request/lock bits.
- Consumes the slot's grant bit and forwards beats onto the shared downstream bus only while granted.
- Keeps the grant locked from the first beat of a packet through its last beat, so packets are never interleaved on the shared bus.

Parameters:
- W, 32, data width in bits.
- DEPTH, 4, input FIFO entries; power of two, >=2.
- STARVE_LIMIT, 16, consecutive ungranted request cycles before starved asserts; >=1.

Ports:
- clock  in  1  single clock.
- reset_n  in  1  asynchronous active-low reset.
- in_valid  in  1  upstream beat valid.
- in_ready  out  1  FIFO not full.
- in_data  in  W  upstream beat.
- in_last  in  1  last beat of packet.
- request  out  1  to this client's arbiter request bit.
- lock  out  1  to this client's arbiter lock bit.
- grant  in  1  this client's arbiter grant bit; combinational from request.
- out_valid  out  1  beat valid on shared bus.
- out_ready  in  1  shared sink accepts beat.
- out_data  out  W  FIFO head data.
- out_last  out  1  FIFO head last flag.
- starved  out  1  request pending >= STARVE_LIMIT cycles without grant.

Behaviour:
- Reset (async assert, sync deassert):
  - FIFO empty; state IDLE; starve counter 0.
  - in_ready=1; request=0, lock=0, out_valid=0, starved=0; out_data/out_last don't-care.
  - Reset mid-packet drops all buffered beats; no partial-packet recovery.
- Handshakes:
  - push = in_valid & in_ready.
  - accept = out_valid & out_ready, which pops the FIFO.
  - Push and pop in the same cycle are allowed at any occupancy, including full: in_ready is based on count only, so a full FIFO does not take a push even when a pop occurs that cycle.
- FIFO: registered count (0..DEPTH, width $clog2(DEPTH)+1) with wrap-around read/write pointers. Head data is visible combinationally on out_data/out_last.
- Combinational loop rule: request and lock must depend only on registered state. They must never depend on grant or out_ready, because the arbiter's grant is combinational from request.
- out_valid = grant & (count!=0).
- States (enum in package):
  - IDLE: count==0 and not mid-packet. request=0, lock=0.
  - ARB: count!=0 and head is the first beat of a packet. request=1, lock=0.
    - accept of a non-last beat -> PKT.
    - accept of a last beat -> ARB if count after pop !=0, else IDLE.
    - no accept -> stay. The grant may be lost to a higher-priority client; this is legal because no beat of the packet has been sent yet.
  - PKT: first beat sent, last not yet sent. request=1 and lock=1 even if the FIFO is empty, so the arbiter's hold (last & lock & request) keeps the grant.
    - An empty FIFO or out_ready=0 just idles the bus, with out_valid=0 when empty.
    - accept of the last beat -> ARB or IDLE as above.
  - IDLE -> ARB the cycle after the first push.
- Lock timing: lock is asserted from the cycle after the first accepted beat through the cycle the last beat is accepted. It drops the cycle after.
- Single-beat packet (in_last=1 on its only beat): no PKT visit; lock stays 0.
- Starve counter:
  - Increments each cycle with request=1 & grant=0, saturating at STARVE_LIMIT.
  - Clears on any cycle with grant=1 or request=0.
  - starved = (counter==STARVE_LIMIT), registered.

Decomposition:
- Package KW_arb_pkg holds the client state enum (IDLE, ARB, PKT) and a clog2-based count-width helper.
- One sub-module, KW_arb_client_fifo: sync FIFO with count, full/empty, and a combinational head.

Test Plan:
- Reset mid-PKT with 3 beats buffered -> request=0, lock=0, in_ready=1, out_valid=0 immediately; after release, a new single beat D=0xA5 last=1 -> request=1 one cycle after push, lock never 1.
- 3-beat packet 0x1,0x2,0x3(last), grant=1 and out_ready=1 throughout -> out_data 0x1,0x2,0x3 on consecutive cycles; lock=0 on beat 0x1 and 1 on 0x2 and 0x3; request=0 the cycle after 0x3.
- Upstream bubble mid-packet: 0x1 sent, 2 idle cycles, then 0x2(last) -> request=1, lock=1, out_valid=0 during the bubble; no state change.
- Grant withheld 16 cycles in ARB (STARVE_LIMIT=16) -> starved=1 the cycle after the 16th ungranted cycle; grant=1 -> starved=0 next cycle.
- Fill DEPTH=4 beats with out_ready=0 -> in_ready=0; a push attempted while full is not taken; one pop next cycle -> in_ready=1.
- Back-to-back single-beat packets 0x7(last),0x8(last) -> lock stays 0; state ARB->ARB->IDLE.

Source files
------------

// File: rtl/kw_arb_pkg.sv
// Shared types and helpers for the lock-arbiter client and its input FIFO.
package kw_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    ARB  = 2'd1,
    PKT  = 2'd2
  } client_state_t;

  // Occupancy counter width able to hold 0..depth inclusive.
  function automatic int count_width(input int depth);
    return $clog2(depth) + 1;
  endfunction

endpackage

// File: rtl/kw_arb_client_fifo.sv
// Synchronous FIFO holding {last, data} beats with a registered count and a
// combinational head so the client can present data the cycle it is granted.
module kw_arb_client_fifo
  import kw_arb_pkg::*;
#(
  parameter int W     = 32,
  parameter int DEPTH = 4,
  localparam int CW   = count_width(DEPTH)
) (
  input  logic          clock,
  input  logic          reset_n,
  input  logic          push,
  input  logic [W-1:0]  wdata,
  input  logic          wlast,
  input  logic          pop,
  output logic [W-1:0]  rdata,
  output logic          rlast,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int PW = $clog2(DEPTH);

  logic [W:0]    mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  assign full    = (count == CW'(DEPTH));
  assign empty   = (count == '0);
  assign do_push = push & ~full;
  assign do_pop  = pop & ~empty;

  // NOTE: sequential state is updated with non-blocking assignments so every
  // flop samples pre-edge values regardless of block ordering.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // NOTE: the storage array has no reset; stale entries are never visible
  // because count and the pointers are reset, and this keeps it RAM-mappable.
  always_ff @(posedge clock) begin
    if (do_push) mem[wr_ptr] <= {wlast, wdata};
  end

  assign {rlast, rdata} = mem[rd_ptr];

endmodule

// File: rtl/kw_arb_client.sv
// Static-priority lock arbiter client: buffers a packet stream, requests the
// shared bus, and holds the grant locked from first to last beat of a packet.
module kw_arb_client
  import kw_arb_pkg::*;
#(
  parameter int W            = 32,
  parameter int DEPTH        = 4,
  parameter int STARVE_LIMIT = 16
) (
  input  logic         clock,
  input  logic         reset_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [W-1:0] in_data,
  input  logic         in_last,
  output logic         request,
  output logic         lock,
  input  logic         grant,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [W-1:0] out_data,
  output logic         out_last,
  output logic         starved
);

  localparam int CW = count_width(DEPTH);
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  client_state_t state;
  client_state_t state_next;
  logic [CW-1:0] count;
  logic [SW-1:0] starve_cnt;
  logic          full;
  logic          empty;
  logic          push;
  logic          accept;
  logic          more_after_pop;

  assign in_ready  = ~full;
  assign push      = in_valid & in_ready;
  assign out_valid = grant & ~empty;
  assign accept    = out_valid & out_ready;

  kw_arb_client_fifo #(
    .W     (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .push    (push),
    .wdata   (in_data),
    .wlast   (in_last),
    .pop     (accept),
    .rdata   (out_data),
    .rlast   (out_last),
    .count   (count),
    .full    (full),
    .empty   (empty)
  );

  // The arbiter's grant is combinational from request, so request/lock come
  // purely from registered state to keep the loop open.
  assign request = (state != IDLE);
  assign lock    = (state == PKT);

  // Whether another packet's head remains once the current beat leaves.
  assign more_after_pop = (count > CW'(1)) | push;

  // NOTE: state_next gets a default before the case so no path leaves it
  // unassigned, which would otherwise infer a latch.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: if (push) state_next = ARB;
      ARB, PKT: begin
        if (accept) begin
          if (!out_last)           state_next = PKT;
          else if (more_after_pop) state_next = ARB;
          else                     state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Counts consecutive ungranted request cycles, saturating at the limit.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      starve_cnt <= '0;
    end else if (request && !grant) begin
      if (starve_cnt != SW'(STARVE_LIMIT)) starve_cnt <= starve_cnt + 1'b1;
    end else begin
      starve_cnt <= '0;
    end
  end

  assign starved = (starve_cnt == SW'(STARVE_LIMIT));

endmodule
